// File: rtl/cr_kme_fifo_unpack_if.sv
// Handshake bundle for the KME 256-to-64 unpacker.
// master = unpacker side, slave = FIFO/consumer side.
interface cr_kme_fifo_unpack_if;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ack;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [1:0]   out_beat;
    logic [15:0]  word_cnt;

    modport master (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ack,
        output out_data,
        output out_valid,
        output out_last,
        output out_beat,
        output word_cnt
    );

    modport slave (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ack,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_beat,
        input  word_cnt
    );
endinterface

// File: rtl/cr_kme_fifo_unpack.sv
// Pops 256-bit words from the KME staging FIFO and replays them as 4x64-bit beats.
// Optional byte reversal per beat: CR_KME_FIFO_UNPACK_BSWAP_EN.
module cr_kme_fifo_unpack (
    input  logic                clk,
    input  logic                rst,
    cr_kme_fifo_unpack_if.master bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [255:0] r_hold;
    logic [1:0]   r_beat;
    logic [1:0]   w_beat_nxt;
    logic [15:0]  r_word_cnt;
    logic         w_accept;
    logic         w_last;
    logic         w_ack;
    logic         w_load;
    logic [63:0]  w_slice;
    logic [63:0]  w_out;

    assign w_last   = (r_beat == 2'd3);
    assign w_accept = (r_state == HOLD) & bus.out_ready;
    // Pop while empty, or in the same cycle the last beat leaves, so words stream bubble-free.
    assign w_ack    = ~rst & bus.in_valid &
                      ((r_state == EMPTY) | (w_accept & w_last));

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_load      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_ack) begin
                    w_state_nxt = HOLD;
                    w_load      = 1'b1;
                    w_beat_nxt  = 2'd0;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    if (!w_last) begin
                        w_beat_nxt = r_beat + 2'd1;
                    end else begin
                        w_beat_nxt = 2'd0;
                        if (w_ack) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = EMPTY;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat     <= 2'd0;
            r_hold     <= '0;
            r_word_cnt <= 16'd0;
        end else begin
            r_beat <= w_beat_nxt;
            if (w_load) begin
                r_hold <= bus.in_data;
            end
            if (w_accept & w_last) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign w_slice = r_hold[{r_beat, 6'd0} +: 64];

`ifdef CR_KME_FIFO_UNPACK_BSWAP_EN
    genvar g;
    for (g = 0; g < 8; g++) begin : g_bswap
        assign w_out[8*g +: 8] = w_slice[8*(7-g) +: 8];
    end
`else
    assign w_out = w_slice;
`endif

    assign bus.in_ack    = w_ack;
    assign bus.out_data  = w_out;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_last  = w_last;
    assign bus.out_beat  = r_beat;
    assign bus.word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_cr_kme_fifo_unpack.sv
// Bench for cr_kme_fifo_unpack: directed steps plus random traffic against
// a queue-based FIFO and beat-stream reference model.
module tb_cr_kme_fifo_unpack;
    logic clk = 1'b0;
    logic rst;

    cr_kme_fifo_unpack_if bus ();

    cr_kme_fifo_unpack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int acks  = 0;
    int vcyc  = 0;
    bit vld_en;

    logic [255:0] fifo_q[$];
    logic [63:0]  m_beats[$];
    logic [15:0]  m_words;

    function automatic logic [63:0] fmt(input logic [63:0] s);
        logic [63:0] r;
`ifdef CR_KME_FIFO_UNPACK_BSWAP_EN
        for (int i = 0; i < 8; i++) r[8*i +: 8] = s[8*(7-i) +: 8];
`else
        r = s;
`endif
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.in_valid = vld_en && (fifo_q.size() > 0);
        bus.in_data  = (fifo_q.size() > 0) ? fifo_q[0] : rnd256();
    endtask

    // One clock: check at negedge, advance model at posedge, re-drive after.
    task automatic cyc();
        logic        ev;
        logic        eack;
        logic        acc;
        logic [1:0]  eb;
        logic [63:0] ed;
        logic [255:0] w;
        @(negedge clk);
        if (rst) begin
            ev   = 1'b0;
            eack = 1'b0;
            eb   = 2'd0;
        end else begin
            ev   = (m_beats.size() > 0);
            eb   = ev ? 2'(4 - m_beats.size()) : 2'd0;
            eack = bus.in_valid &
                   (!ev | (bus.out_ready & (m_beats.size() == 1)));
        end
        ed = ev ? m_beats[0] : 64'd0;
        chk("out_valid", 64'(bus.out_valid), 64'(ev));
        chk("in_ack", 64'(bus.in_ack), 64'(eack));
        chk("out_beat", 64'(bus.out_beat), 64'(eb));
        chk("out_last", 64'(bus.out_last), 64'(ev && eb == 2'd3));
        chk("word_cnt", 64'(bus.word_cnt), 64'(m_words));
        if (ev || rst) chk("out_data", bus.out_data, ed);
        acc = ev & bus.out_ready;
        if (eack) acks++;
        if (ev) vcyc++;
        @(posedge clk);
        if (rst) begin
            m_beats.delete();
            m_words = 16'd0;
        end else begin
            if (acc) begin
                void'(m_beats.pop_front());
                if (m_beats.size() == 0) m_words++;
            end
            if (eack) begin
                w = fifo_q.pop_front();
                for (int n = 0; n < 4; n++) m_beats.push_back(fmt(w[64*n +: 64]));
            end
        end
        #1;
        drive();
    endtask

    initial begin
        logic [255:0] w0;
        logic [63:0]  bsw_exp;
        bit           hit;

        // Reset with a word waiting: no pop may occur.
        rst = 1'b1;
        vld_en = 1'b1;
        bus.out_ready = 1'b0;
        m_words = 16'd0;
        fifo_q.push_back(rnd256());
        drive();
        repeat (3) cyc();
        fifo_q.delete();
        drive();
        rst = 1'b0;
        cyc();

        // Single word, beat n = n.
        w0 = {64'd3, 64'd2, 64'd1, 64'd0};
        bus.out_ready = 1'b1;
        acks = 0;
        fifo_q.push_back(w0);
        drive();
        repeat (7) cyc();
        chk("single_acks", 64'(acks), 64'd1);
        chk("single_wcnt", 64'(bus.word_cnt), 64'd1);
        chk("single_idle", 64'(bus.out_valid), 64'd0);

        // Back-to-back three words.
        acks = 0;
        vcyc = 0;
        repeat (3) fifo_q.push_back(rnd256());
        drive();
        repeat (14) cyc();
        chk("b2b_acks", 64'(acks), 64'd3);
        chk("b2b_beats", 64'(vcyc), 64'd12);
        chk("b2b_wcnt", 64'(bus.word_cnt), 64'd4);

        // Backpressure at beat 2 with the next word waiting.
        repeat (2) fifo_q.push_back(rnd256());
        drive();
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cyc();
            hit = (m_beats.size() == 2);
        end
        chk("bp_beat2", 64'(bus.out_beat), 64'd2);
        bus.out_ready = 1'b0;
        acks = 0;
        repeat (5) cyc();
        chk("bp_noack", 64'(acks), 64'd0);
        bus.out_ready = 1'b1;
        repeat (10) cyc();

        // Starvation, then in_valid rises.
        vld_en = 1'b0;
        fifo_q.push_back(rnd256());
        drive();
        repeat (4) cyc();
        chk("starve_empty", 64'(bus.out_valid), 64'd0);
        vld_en = 1'b1;
        drive();
        acks = 0;
        cyc();
        chk("starve_ack", 64'(acks), 64'd1);
        chk("starve_v", 64'(bus.out_valid), 64'd1);
        chk("starve_b0", 64'(bus.out_beat), 64'd0);
        repeat (5) cyc();

        // Reset mid-word at beat 1.
        repeat (2) fifo_q.push_back(rnd256());
        drive();
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cyc();
            hit = (m_beats.size() == 3);
        end
        chk("rst_beat1", 64'(bus.out_beat), 64'd1);
        rst = 1'b1;
        m_beats.delete();
        m_words = 16'd0;
        repeat (2) cyc();
        chk("rst_keep", 64'(fifo_q.size()), 64'd1);
        rst = 1'b0;
        drive();
        repeat (8) cyc();
        chk("rst_wcnt", 64'(bus.word_cnt), 64'd1);

        // Byte-order check on a known beat 0.
        w0 = rnd256();
        w0[63:0] = 64'h0011223344556677;
`ifdef CR_KME_FIFO_UNPACK_BSWAP_EN
        bsw_exp = 64'h7766554433221100;
`else
        bsw_exp = 64'h0011223344556677;
`endif
        bus.out_ready = 1'b0;
        fifo_q.push_back(w0);
        drive();
        cyc();
        chk("bswap_b0", bus.out_data, bsw_exp);
        bus.out_ready = 1'b1;
        repeat (6) cyc();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(2) == 0)
                fifo_q.push_back(rnd256());
            vld_en = ($urandom_range(4) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            drive();
            cyc();
        end
        vld_en = 1'b1;
        bus.out_ready = 1'b1;
        drive();
        repeat (40) cyc();
        chk("drain_fifo", 64'(fifo_q.size()), 64'd0);
        chk("drain_idle", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cr_kme_fifo_unpack.md
# cr_kme_fifo_unpack

Downstream width converter for the KME 256-bit staging FIFO. It pops one 256-bit word at a time from the FIFO's read side (`fifo_out`/`fifo_out_valid`/`fifo_out_ack`). It replays each word as four 64-bit beats on a valid/ready stream toward the key-engine datapath. It holds exactly one word and pops the next word in the same cycle the last beat of the current word is accepted, so back-to-back words stream with no bubble.

## Interface
- No parameters; widths fixed: input 256 bits, output 64 bits, 4 beats per word.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  256  word from FIFO `fifo_out`; beat n = `in_data[64n+63:64n]`.
- `in_valid`  in  1  FIFO `fifo_out_valid`.
- `in_ack`  out  1  pop strobe to FIFO `fifo_out_ack`; combinational.
- `out_data`  out  64  current beat, registered.
- `out_valid`  out  1  beat valid, registered.
- `out_ready`  in  1  downstream accepts the beat when `out_valid & out_ready`.
- `out_last`  out  1  current beat is beat 3 of its word.
- `out_beat`  out  2  index of the current beat, 0..3.
- `word_cnt`  out  16  count of words fully emitted; wraps from 0xFFFF to 0.

## Operation
- State: `EMPTY` (no word held) or `HOLD` (256-bit holding register valid, `out_valid`=1).
- Beat counter `beat[1:0]`. `out_data` is the beat-indexed slice of the holding register. `out_last` = (beat==3).
- `accept` = `out_valid & out_ready`.
- `in_ack` = `!rst & in_valid & (state==EMPTY | (accept & beat==3))`.
- A word transfers when `in_ack`=1. The FIFO pops when `in_ack`=1 and `in_valid`=1.
- EMPTY, `in_ack`=1 → HOLD; holding register loaded; beat=0.
- HOLD, `accept` and beat<3 → beat+1; stay HOLD.
- HOLD, `accept` and beat==3:
  - `in_valid`=1: reload the holding register; beat=0; stay HOLD.
  - `in_valid`=0: go to EMPTY; beat=0.
- HOLD, no `accept`: all state held. `out_data` and `out_beat` stay stable while `out_valid`=1 and `out_ready`=0.
- `word_cnt` increments by 1 on every `accept` with beat==3. Arithmetic is modulo 2^16.
- No output changes while `in_valid`=1 in HOLD with the current word not finished; `in_ack` stays 0.

## Timing
- Reset values: state=EMPTY, beat=0, holding register=0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_beat`=0, `word_cnt`=0.
- `in_ack` is forced 0 while `rst`=1.
- Reset asserted mid-word: the held word and any un-emitted beats are discarded. No pop occurs during reset.
- Latency:
  - Word popped in cycle T (EMPTY) → beat 0 valid in T+1.
  - With `out_ready` held at 1, beats appear in T+1..T+4.
  - The next word is popped in T+4, and its beat 0 appears in T+5.
  - Sustained throughput: 1 beat/cycle, 1 word/4 cycles.
- `in_ack` depends combinationally on `in_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- Simultaneous last-beat accept and pop: the new beat 0 replaces beat 3 on the next edge; `out_valid` stays 1.

## Configuration
- `CR_KME_FIFO_UNPACK_BSWAP_EN`
  - Defined: each 64-bit beat is byte-reversed on `out_data`. Byte 0 of the slice (bits 7:0) appears on `out_data[63:56]`.
  - Undefined: the slice passes unmodified.
- Beat order, handshake, latency and `word_cnt` are identical in both builds.

## Test plan
- Single word, `out_ready`=1: `in_data`=0x…_0003_0002_0001_0000 (beat n = n), pushed once.
  - `in_ack` is high for 1 cycle.
  - `out_data` = 0,1,2,3 on 4 consecutive cycles; `out_last` is high only on 3; `word_cnt`=1; then `out_valid`=0.
- Back-to-back: FIFO holds 3 words, `out_ready`=1 → 12 contiguous beats with no bubble, `in_ack` pulses at beats 0(first load), 3, 7, and `word_cnt`=3.
- Backpressure: `out_ready`=0 for 5 cycles at beat 2 → `out_data`, `out_beat`=2 and `out_valid` are stable; `in_ack`=0 throughout; the stream resumes at beat 2.
- Starvation: last beat accepted with `in_valid`=0 → EMPTY next cycle. `in_valid` rising later → `in_ack` is high in the same cycle, and beat 0 appears one cycle later.
- Reset mid-word at beat 1: all outputs return to 0; no extra pop occurs. The FIFO's next word emits from beat 0 after reset is released.
- With `CR_KME_FIFO_UNPACK_BSWAP_EN`: beat 0 = 0x0011223344556677 → `out_data`=0x7766554433221100.
